// File: rtl/raster_counter_pkg.sv
// Shared types for the raster position tracker: FSM states and the packed
// position-flag bundle with its encoding helper.
package raster_counter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } flags_t;

  localparam flags_t FLAGS_NONE = '{sof: 1'b0, eol: 1'b0, eof: 1'b0};

  // Flags only exist while a frame is running; in IDLE every flag is low.
  function automatic flags_t make_flags(input logic active,
                                        input logic x_zero,
                                        input logic y_zero,
                                        input logic x_term,
                                        input logic y_term);
    flags_t f;
    f = FLAGS_NONE;
    if (active) begin
      f.sof = x_zero & y_zero;
      f.eol = x_term;
      f.eof = x_term & y_term;
    end
    return f;
  endfunction

endpackage

// File: rtl/raster_counter_if.sv
// Control/status bundle between a pixel-stream observer and raster_counter.
// Signal suffixes are from the counter's point of view (slave side).
interface raster_counter_if #(
  parameter int X_WIDTH_P     = 10,
  parameter int Y_WIDTH_P     = 10,
  parameter int FRAME_WIDTH_P = 16
);
  logic                     start_i;
  logic [X_WIDTH_P-1:0]     cols_i;
  logic [Y_WIDTH_P-1:0]     rows_i;
  logic                     step_i;
  logic                     abort_i;
  logic [X_WIDTH_P-1:0]     x_o;
  logic [Y_WIDTH_P-1:0]     y_o;
  logic                     active_o;
  logic                     sof_o;
  logic                     eol_o;
  logic                     eof_o;
  logic                     done_o;
  logic                     cfg_err_o;
  logic [FRAME_WIDTH_P-1:0] frame_cnt_o;

  modport master (
    output start_i, cols_i, rows_i, step_i, abort_i,
    input  x_o, y_o, active_o, sof_o, eol_o, eof_o, done_o, cfg_err_o, frame_cnt_o
  );

  modport slave (
    input  start_i, cols_i, rows_i, step_i, abort_i,
    output x_o, y_o, active_o, sof_o, eol_o, eof_o, done_o, cfg_err_o, frame_cnt_o
  );
endinterface

// File: rtl/raster_counter_limit_counter.sv
// Modulo counter for one raster axis: counts 0..limit_i-1, wraps on inc at term.
// Single-cycle update; clr_i has priority over inc_i.
module limit_counter #(
  parameter int WIDTH_P = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [WIDTH_P-1:0] limit_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               term_o
);

  localparam logic [WIDTH_P-1:0] ONE = WIDTH_P'(1);

  logic [WIDTH_P-1:0] count_q, count_d;

  assign term_o  = (count_q == (limit_i - ONE));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = term_o ? '0 : (count_q + ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/raster_counter.sv
// Tracks (x,y) of a pixel stream over a programmable frame; flags are combinational
// from registered position, done/cfg_err pulse one cycle after the causing beat.
module raster_counter
  import raster_counter_pkg::*;
#(
  parameter int X_WIDTH_P     = 10,
  parameter int Y_WIDTH_P     = 10,
  parameter int FRAME_WIDTH_P = 16,
  parameter int CONTINUOUS_P  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  raster_counter_if.slave   bus
);

  state_e                   state_q, state_d;
  logic [X_WIDTH_P-1:0]     cols_q, cols_d;
  logic [Y_WIDTH_P-1:0]     rows_q, rows_d;
  logic [FRAME_WIDTH_P-1:0] frame_cnt_q, frame_cnt_d;
  logic                     done_q, done_d;
  logic                     cfg_err_q, cfg_err_d;

  logic                     run;
  logic                     clr;
  logic                     x_inc;
  logic                     y_inc;
  logic                     x_term;
  logic                     y_term;
  logic [X_WIDTH_P-1:0]     x_cnt;
  logic [Y_WIDTH_P-1:0]     y_cnt;
  flags_t                   flags;

  assign run = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    rows_d      = rows_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    clr         = 1'b0;
    x_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        // abort in IDLE only serves to veto a simultaneous start
        if (bus.start_i && !bus.abort_i) begin
          if ((bus.cols_i == '0) || (bus.rows_i == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            cols_d  = bus.cols_i;
            rows_d  = bus.rows_i;
            clr     = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (bus.step_i) begin
          x_inc = 1'b1;
          if (x_term && y_term) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            done_d      = 1'b1;
            if (CONTINUOUS_P == 0) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Both axes wrap together at eof, so the position is back at (0,0) for free.
  assign y_inc = x_inc & x_term;

  limit_counter #(.WIDTH_P(X_WIDTH_P)) u_x_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .inc_i   (x_inc),
    .limit_i (cols_q),
    .count_o (x_cnt),
    .term_o  (x_term)
  );

  limit_counter #(.WIDTH_P(Y_WIDTH_P)) u_y_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .inc_i   (y_inc),
    .limit_i (rows_q),
    .count_o (y_cnt),
    .term_o  (y_term)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign flags = make_flags(run, (x_cnt == '0), (y_cnt == '0), x_term, y_term);

  assign bus.x_o         = x_cnt;
  assign bus.y_o         = y_cnt;
  assign bus.active_o    = run;
  assign bus.sof_o       = flags.sof;
  assign bus.eol_o       = flags.eol;
  assign bus.eof_o       = flags.eof;
  assign bus.done_o      = done_q;
  assign bus.cfg_err_o   = cfg_err_q;
  assign bus.frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_raster_counter.sv
// Two instances (one-shot and continuous) checked every cycle against a
// linear-pixel-index model, plus directed literal checks.
module tb_raster_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  raster_counter_if #(.X_WIDTH_P(10), .Y_WIDTH_P(10), .FRAME_WIDTH_P(16)) if0 ();
  raster_counter_if #(.X_WIDTH_P(4),  .Y_WIDTH_P(4),  .FRAME_WIDTH_P(2))  if1 ();

  raster_counter #(.X_WIDTH_P(10), .Y_WIDTH_P(10), .FRAME_WIDTH_P(16), .CONTINUOUS_P(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0.slave));
  raster_counter #(.X_WIDTH_P(4), .Y_WIDTH_P(4), .FRAME_WIDTH_P(2), .CONTINUOUS_P(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.slave));

  bit d_start[2], d_step[2], d_abort[2];
  int d_cols[2], d_rows[2];

  assign if0.start_i = d_start[0];
  assign if0.cols_i  = d_cols[0][9:0];
  assign if0.rows_i  = d_rows[0][9:0];
  assign if0.step_i  = d_step[0];
  assign if0.abort_i = d_abort[0];
  assign if1.start_i = d_start[1];
  assign if1.cols_i  = d_cols[1][3:0];
  assign if1.rows_i  = d_rows[1][3:0];
  assign if1.step_i  = d_step[1];
  assign if1.abort_i = d_abort[1];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame position as a linear pixel index p; x = p % cols, y = p / cols.
  int m_run[2], m_cols[2], m_rows[2], m_p[2], m_fc[2], m_done[2], m_err[2];
  int m_fmod[2] = '{65536, 4};
  int m_cont[2] = '{0, 1};

  task automatic tick(input int k);
    m_done[k] = 0;
    m_err[k]  = 0;
    if (rst) begin
      m_run[k] = 0; m_cols[k] = 0; m_rows[k] = 0; m_p[k] = 0; m_fc[k] = 0;
    end else if (m_run[k] != 0) begin
      if (d_abort[k]) begin
        m_run[k] = 0; m_p[k] = 0;
      end else if (d_step[k]) begin
        if (m_p[k] == m_cols[k] * m_rows[k] - 1) begin
          m_p[k]    = 0;
          m_fc[k]   = (m_fc[k] + 1) % m_fmod[k];
          m_done[k] = 1;
          if (m_cont[k] == 0) m_run[k] = 0;
        end else begin
          m_p[k] = m_p[k] + 1;
        end
      end
    end else if (d_start[k] && !d_abort[k]) begin
      if (d_cols[k] == 0 || d_rows[k] == 0) begin
        m_err[k] = 1;
      end else begin
        m_run[k] = 1; m_cols[k] = d_cols[k]; m_rows[k] = d_rows[k]; m_p[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    tick(0);
    tick(1);
  end

  task automatic cmp(input int k, input int x, input int y, input bit act, input bit sof,
                     input bit eol, input bit eof, input bit done, input bit err, input int fc);
    int ex, ey;
    bit run;
    run = (m_run[k] != 0);
    ex  = run ? m_p[k] % m_cols[k] : 0;
    ey  = run ? m_p[k] / m_cols[k] : 0;
    check($sformatf("x_o[%0d]", k), x, ex);
    check($sformatf("y_o[%0d]", k), y, ey);
    check($sformatf("active_o[%0d]", k), act, run);
    check($sformatf("sof_o[%0d]", k), sof, run && m_p[k] == 0);
    check($sformatf("eol_o[%0d]", k), eol, run && ex == m_cols[k] - 1);
    check($sformatf("eof_o[%0d]", k), eof, run && m_p[k] == m_cols[k] * m_rows[k] - 1);
    check($sformatf("done_o[%0d]", k), done, m_done[k]);
    check($sformatf("cfg_err_o[%0d]", k), err, m_err[k]);
    check($sformatf("frame_cnt_o[%0d]", k), fc, m_fc[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, if0.x_o, if0.y_o, if0.active_o, if0.sof_o, if0.eol_o, if0.eof_o,
          if0.done_o, if0.cfg_err_o, if0.frame_cnt_o);
      cmp(1, if1.x_o, if1.y_o, if1.active_o, if1.sof_o, if1.eol_o, if1.eof_o,
          if1.done_o, if1.cfg_err_o, if1.frame_cnt_o);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k, input int c, input int r);
    d_start[k] = 1; d_cols[k] = c; d_rows[k] = r;
    cyc();
    d_start[k] = 0;
  endtask

  task automatic do_steps(input int k, input int n);
    repeat (n) begin
      d_step[k] = 1;
      cyc();
      d_step[k] = 0;
    end
  endtask

  // 4x3 frame on the one-shot instance, optionally with an idle cycle between beats.
  task automatic frame_4x3(input bit gap, input int fc_after);
    do_start(0, 4, 3);
    check("frame_sof", if0.sof_o, 1);
    for (int i = 0; i < 12; i++) begin
      check("frame_eol", if0.eol_o, (i % 4) == 3);
      check("frame_eof", if0.eof_o, i == 11);
      if (i == 11) begin
        check("frame_eof_x", if0.x_o, 3);
        check("frame_eof_y", if0.y_o, 2);
      end
      d_step[0] = 1;
      cyc();
      d_step[0] = 0;
      if (i < 11) check("frame_no_done", if0.done_o, 0);
      if (gap && i < 11) begin
        cyc();
        check("gap_hold_x", if0.x_o, (i + 1) % 4);
        check("gap_hold_y", if0.y_o, (i + 1) / 4);
      end
    end
    check("frame_done", if0.done_o, 1);
    check("frame_cnt", if0.frame_cnt_o, fc_after);
    check("frame_idle", if0.active_o, 0);
    cyc();
    check("frame_done_pulse", if0.done_o, 0);
  endtask

  initial begin
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      d_start[k] = 0; d_step[k] = 0; d_abort[k] = 0; d_cols[k] = 0; d_rows[k] = 0;
    end
    cyc();
    chk_en = 1;
    check("rst_active", if0.active_o, 0);
    check("rst_fc", if0.frame_cnt_o, 0);
    cyc();
    rst = 0;
    cyc();

    // Reset mid-frame
    do_start(0, 4, 3);
    do_steps(0, 5);
    check("pre_rst_x", if0.x_o, 1);
    check("pre_rst_y", if0.y_o, 1);
    rst = 1;
    cyc();
    rst = 0;
    check("mid_rst_x", if0.x_o, 0);
    check("mid_rst_y", if0.y_o, 0);
    check("mid_rst_active", if0.active_o, 0);
    check("mid_rst_done", if0.done_o, 0);
    check("mid_rst_fc", if0.frame_cnt_o, 0);
    cyc();

    frame_4x3(1'b0, 1);
    frame_4x3(1'b1, 2);

    // Rejected configuration, then 1x1 frame
    do_start(0, 0, 5);
    check("cfg_err_pulse", if0.cfg_err_o, 1);
    check("cfg_err_idle", if0.active_o, 0);
    cyc();
    check("cfg_err_clear", if0.cfg_err_o, 0);
    do_start(0, 1, 1);
    check("one_sof", if0.sof_o, 1);
    check("one_eol", if0.eol_o, 1);
    check("one_eof", if0.eof_o, 1);
    do_steps(0, 1);
    check("one_done", if0.done_o, 1);
    check("one_fc", if0.frame_cnt_o, 3);

    // Abort priority
    do_start(0, 8, 8);
    do_steps(0, 10);
    check("abort_pre_x", if0.x_o, 2);
    check("abort_pre_y", if0.y_o, 1);
    d_abort[0] = 1; d_step[0] = 1;
    cyc();
    d_step[0] = 0;
    check("abort_idle", if0.active_o, 0);
    check("abort_x", if0.x_o, 0);
    check("abort_y", if0.y_o, 0);
    check("abort_no_done", if0.done_o, 0);
    check("abort_fc", if0.frame_cnt_o, 3);
    d_start[0] = 1; d_cols[0] = 0; d_rows[0] = 5;
    cyc();
    check("abort_start_no_err", if0.cfg_err_o, 0);
    d_cols[0] = 4; d_rows[0] = 3;
    cyc();
    check("abort_start_idle", if0.active_o, 0);
    d_start[0] = 0; d_abort[0] = 0;
    cyc();

    // Continuous instance: 2x2 frames, restart attempt mid-run is ignored
    do_start(1, 2, 2);
    for (int s = 1; s <= 20; s++) begin
      if (s == 10) begin
        d_start[1] = 1; d_cols[1] = 3; d_rows[1] = 3;
      end
      d_step[1] = 1;
      cyc();
      d_step[1] = 0; d_start[1] = 0;
      check("cont_done", if1.done_o, (s % 4) == 0);
      if ((s % 4) == 0) check("cont_fc", if1.frame_cnt_o, (s / 4) % 4);
      check("cont_active", if1.active_o, 1);
    end
    d_abort[1] = 1;
    cyc();
    d_abort[1] = 0;
    check("cont_abort_idle", if1.active_o, 0);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      for (int k = 0; k < 2; k++) begin
        d_start[k] = ($urandom_range(7) == 0);
        d_cols[k]  = $urandom_range(5);
        d_rows[k]  = $urandom_range(4);
        d_step[k]  = $urandom_range(1);
        d_abort[k] = ($urandom_range(39) == 0);
      end
      cyc();
    end
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      d_start[k] = 0; d_step[k] = 0; d_abort[k] = 0;
    end
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
